// File: rtl/complex_pkg.sv
// Shared types and constants for the RV32M complex (multiply/divide) unit.
package complex_pkg;

    localparam int DIV_ITERS = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } cu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL1,
        ST_MUL2,
        ST_DIV,
        ST_FIX
    } cu_state_e;

endpackage

// File: rtl/complex_divider.sv
// Restoring radix-2 divider core on unsigned magnitudes.
module complex_divider
    import complex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [32:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] div_q;
    logic [4:0]  cnt_q;
    logic        active_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    // Dividend bits shift out of the quotient register into the remainder.
    assign shifted = {rem_q[31:0], quot_q[31]};
    assign diff    = shifted - {1'b0, div_q};
    assign fits    = shifted >= {1'b0, div_q};
    assign done    = active_q && (cnt_q == 5'(DIV_ITERS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            quot_q   <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            rem_q    <= '0;
            quot_q   <= dividend;
            div_q    <= divisor;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q  <= fits ? diff : shifted;
            quot_q <= {quot_q[30:0], fits};
            cnt_q  <= cnt_q + 5'd1;
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[32];

    assign quotient  = quot_q;
    assign remainder = rem_q[31:0];

endmodule

// File: rtl/complex_unit.sv
// Iterative RV32M multiply/divide unit with single-cycle write-back pulse.
module complex_unit
    import complex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            cpu_clk_i,
    input  logic            cpu_rst_i,
    input  logic            cu_valid_i,
    input  logic [2:0]      cu_opcode_i,
    input  logic [XLEN-1:0] cu_operand1_i,
    input  logic [XLEN-1:0] cu_operand2_i,
    output logic            busy_o,
    output logic [XLEN-1:0] result_o,
    output logic            wb_valid_o
);

    cu_state_e state, next;

    cu_op_e      op_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        div0_q;
    logic        ovf_q;
    logic [65:0] prod_q;

    cu_op_e      op;
    logic        is_mul;
    logic        sdiv;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        div0;
    logic        ovf;
    logic        accept;
    logic        div_start;
    logic        div_done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign op     = cu_op_e'(cu_opcode_i);
    assign is_mul = !cu_opcode_i[2];
    assign sdiv   = (op == OP_DIV) || (op == OP_REM);
    assign a_neg  = sdiv && cu_operand1_i[31];
    assign b_neg  = sdiv && cu_operand2_i[31];
    assign a_abs  = a_neg ? -cu_operand1_i : cu_operand1_i;
    assign b_abs  = b_neg ? -cu_operand2_i : cu_operand2_i;
    assign div0   = (cu_operand2_i == '0);
    assign ovf    = sdiv && (cu_operand1_i == INT_MIN)
                    && (cu_operand2_i == '1);
    assign accept = cu_valid_i && (state == ST_IDLE);
    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next      = state;
        div_start = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cu_valid_i) begin
                    if (is_mul) begin
                        next = ST_MUL1;
                    end else if (div0 || ovf) begin
                        next = ST_FIX;
                    end else begin
                        next      = ST_DIV;
                        div_start = 1'b1;
                    end
                end
            end
            ST_MUL1: next = ST_MUL2;
            ST_MUL2: next = ST_IDLE;
            ST_DIV:  if (div_done) next = ST_FIX;
            ST_FIX:  next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    complex_divider u_div (
        .clk       (cpu_clk_i),
        .rst       (cpu_rst_i),
        .start     (div_start),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // 33-bit extension lets one signed multiplier cover all four forms.
    logic signed [32:0] a_ext;
    logic signed [32:0] b_ext;
    logic signed [65:0] product;

    assign a_ext = (op_q == OP_MULHU) ? {1'b0, op1_q}
                                      : {op1_q[31], op1_q};
    assign b_ext = (op_q == OP_MUL || op_q == OP_MULH)
                   ? {op2_q[31], op2_q} : {1'b0, op2_q};
    assign product = a_ext * b_ext;

    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic [31:0] fix_result;

    always_comb begin
        div_quot = q_neg_q ? -quotient : quotient;
        div_rem  = r_neg_q ? -remainder : remainder;
        if (div0_q) begin
            div_quot = DIV_BY_ZERO_Q;
            div_rem  = op1_q;
        end else if (ovf_q) begin
            div_quot = INT_MIN;
            div_rem  = '0;
        end
        fix_result = (op_q == OP_DIV || op_q == OP_DIVU)
                     ? div_quot : div_rem;
    end

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            op_q       <= OP_MUL;
            op1_q      <= '0;
            op2_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            prod_q     <= '0;
            result_o   <= '0;
            wb_valid_o <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            if (accept) begin
                op_q    <= op;
                op1_q   <= cu_operand1_i;
                op2_q   <= cu_operand2_i;
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                div0_q  <= div0;
                ovf_q   <= ovf;
            end
            if (state == ST_MUL1) begin
                prod_q <= product;
            end
            if (state == ST_MUL2) begin
                result_o   <= (op_q == OP_MUL) ? prod_q[31:0]
                                               : prod_q[63:32];
                wb_valid_o <= 1'b1;
            end
            if (state == ST_FIX) begin
                result_o   <= fix_result;
                wb_valid_o <= 1'b1;
            end
        end
    end

    logic unused_prod_hi;
    assign unused_prod_hi = ^prod_q[65:64];

    a_no_issue_busy: assert property (
        @(posedge cpu_clk_i) disable iff (cpu_rst_i)
        !(cu_valid_i && state != ST_IDLE)
    ) else $warning("complex_unit: cu_valid_i while busy was dropped");

endmodule

// File: doc/complex_unit.md
# complex_unit

Iterative multiply/divide unit implementing the RV32M operations for the memory scheduler's complex path. It accepts one operation at a time from the scheduler's `cu_*` issue interface. It returns a single-cycle write-back pulse with the 32-bit result. It holds `busy_o` only while computing, so the scheduler can retire the op in the write-back cycle. All ops are non-speculative (issued only when oldest in ROB), so there is no flush port: an accepted op always completes unless reset.

## Interface
- `XLEN`, 32, operand/result width; only 32 supported.
- `cpu_clk_i`  in  1  clock.
- `cpu_rst_i`  in  1  asynchronous, active-high reset.
- `cu_valid_i`  in  1  single-cycle request strobe.
- `cu_opcode_i`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `cu_operand1_i`  in  32  rs1 value.
- `cu_operand2_i`  in  32  rs2 value.
- `busy_o`  out  1  op in flight, not yet written back.
- `result_o`  out  32  result; valid when `wb_valid_o`, held afterwards.
- `wb_valid_o`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, MUL1, MUL2, DIV, FIX.
- **Accept:** `cu_valid_i` is sampled only in IDLE. The accept edge is E0.
  - Opcode and operands are registered at E0.
  - `cu_valid_i` outside IDLE is ignored; it is a protocol violation and must trip an assertion.
- **Multiply path (IDLE→MUL1→MUL2→IDLE):**
  - Operands are extended to 33 bits per opcode: signed/signed for MUL/MULH, signed/unsigned for MULHSU, unsigned/unsigned for MULHU.
  - E1 registers the 66-bit product.
  - E2 writes `result_o` (product[31:0] for MUL, product[63:32] otherwise) and `wb_valid_o`.
- **Divide path (IDLE→DIV→FIX→IDLE):**
  - E0 registers |a| and |b| (plain values for unsigned ops), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]), each for signed ops only. It also registers the special-case flags.
  - DIV runs 32 restoring radix-2 iterations, E1..E32, on a 33-bit partial remainder with a 5-bit counter.
  - FIX applies sign correction: quotient negated if its sign flag is set; remainder negated if its sign flag is set.
  - E33 writes `result_o` and `wb_valid_o`.
- **Special cases** (detected at E0): IDLE→FIX, skipping DIV; write-back at E1.
  - Divide by zero: quotient 0xFFFFFFFF; remainder = rs1.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000; remainder 0.
- **`busy_o`:** high in MUL1, MUL2, DIV and FIX; low in IDLE. It is therefore low in the write-back cycle.
- **`wb_valid_o`:** registered, high exactly one cycle. That cycle is in IDLE, so a new op may be accepted in it.

## Timing
- **Reset values:** state IDLE, `busy_o`=0, `wb_valid_o`=0, `result_o`=0. Reset mid-operation discards the op with no write-back.
- **Latency** (write-back visible in the cycle after the edge listed): MUL* E2; normal DIV*/REM* E33; special-case divides E1.
- **Throughput:** back-to-back ops are possible, with the next `cu_valid_i` accepted in the write-back cycle.
- **Arithmetic:** all arithmetic is two's complement modulo 2^32 on outputs. Negating 0x80000000 yields 0x80000000, so no special handling is needed beyond the overflow flag.

## Structure
- **Shared package `complex_pkg`:** opcode enum `cu_op_e`, the state enum, and the constants `DIV_ITERS`=32 and `DIV_BY_ZERO_Q`=0xFFFFFFFF.
- **Sub-module `complex_divider`:** iterative core (partial remainder, quotient shift register, counter) with start/done handshake. The top level owns the FSM, sign handling, the multiplier and output registers.

## Test plan
1. MUL 7 × 0xFFFFFFFD -> `result_o`=0xFFFFFFEB; `wb_valid_o` pulses one cycle after E2; `busy_o` high exactly 2 cycles.
2. High-half multiplies:
   - MULH 0x80000000×0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed division of -7 by 2:
   - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM -> 0xFFFFFFFF.
   - Write-back after E33; `busy_o` high 33 cycles and low in the write-back cycle.
4. Special cases, each with write-back after E1:
   - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
5. Reset and protocol violations:
   - Assert `cpu_rst_i` at iteration 10 of DIVU -> `busy_o`/`wb_valid_o` drop immediately, no pulse. A following MUL 3×4 returns 12.
   - `cu_valid_i` pulsed while busy is ignored (assertion fires) and the original result is unchanged.
6. Back-to-back: `cu_valid_i` asserted in the write-back cycle of a MUL -> second op accepted, and its result follows with correct latency.
